bsc_stub_sink: RTL and testbench



---
 rtl/bsc_stub_sink.sv | 111 +++++++++++
 tb/tb_bsc_stub_sink.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsc_stub_sink.sv
// Stub valid/ready sink: terminates NUM_CH streams with a selectable ready pattern
// and keeps a saturating beat count, sticky overflow flag and data signature per channel.
module bsc_stub_sink #(
    parameter int unsigned NUM_CH       = 1,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned MODE         = 0,
    parameter int unsigned READY_PERIOD = 4,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [NUM_CH-1:0]           in_valid,
    input  logic [NUM_CH*WIDTH-1:0]     in_data,
    output logic [NUM_CH-1:0]           in_ready,
    output logic [NUM_CH*CNT_WIDTH-1:0] beat_count,
    output logic [NUM_CH*WIDTH-1:0]     signature,
    output logic [NUM_CH-1:0]           overflow
);

    if (MODE > 2 || NUM_CH == 0 || WIDTH == 0 || READY_PERIOD == 0 || CNT_WIDTH == 0)
    begin : g_param_check
        $error("bsc_stub_sink: illegal parameter combination");
    end

    localparam int unsigned PhaseWidth = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
    localparam logic [PhaseWidth-1:0] PhaseLast = PhaseWidth'(READY_PERIOD - 1);

    logic [PhaseWidth-1:0] phase_q, phase_d;
    logic                  mode_ready;
    logic                  ready;

    always_comb begin
        phase_d = phase_q;
        if (clear) begin
            phase_d = '0;
        end else if (phase_q == PhaseLast) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PhaseWidth'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        mode_ready = 1'b0;
        if (MODE == 0) begin
            mode_ready = 1'b1;
        end else if (MODE == 1) begin
            mode_ready = (phase_q == PhaseLast);
        end
    end

    // Gating with reset keeps ready low for the whole reset pulse, even when phase decodes true.
    assign ready    = mode_ready & ~clear & ~reset;
    assign in_ready = {NUM_CH{ready}};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0]     sig_q, sig_d;
        logic                 ovf_q, ovf_d;
        logic [WIDTH-1:0]     data;
        logic                 beat;

        assign data = in_data[c*WIDTH +: WIDTH];
        assign beat = in_valid[c] & ready;

        always_comb begin
            cnt_d = cnt_q;
            sig_d = sig_q;
            ovf_d = ovf_q;
            if (clear) begin
                cnt_d = '0;
                sig_d = '0;
                ovf_d = 1'b0;
            end else if (beat) begin
                if (&cnt_q) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                // Rotate-left by one; collapses to identity when WIDTH is 1.
                sig_d = ((sig_q << 1) | (sig_q >> (WIDTH - 1))) ^ data;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                sig_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                sig_q <= sig_d;
                ovf_q <= ovf_d;
            end
        end

        assign beat_count[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        assign signature[c*WIDTH +: WIDTH]          = sig_q;
        assign overflow[c]                          = ovf_q;
    end

endmodule

// File: tb/tb_bsc_stub_sink.sv
// Bench for bsc_stub_sink: three instances (always-ready, periodic, stalled) checked every cycle
// against a beat-count/signature model derived from the handshake rules.
module tb_bsc_stub_sink;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: MODE 0, two channels, 3-bit counters so saturation is reachable.
    logic        a_clear;
    logic [1:0]  a_valid;
    logic [15:0] a_data;
    logic [1:0]  a_ready;
    logic [5:0]  a_count;
    logic [15:0] a_sig;
    logic [1:0]  a_ovf;

    // Instance B: MODE 1, period 4, one channel.
    logic        b_clear;
    logic        b_valid;
    logic [7:0]  b_data;
    logic        b_ready;
    logic [7:0]  b_count;
    logic [7:0]  b_sig;
    logic        b_ovf;

    // Instance C: MODE 2, never ready.
    logic        c_clear;
    logic [1:0]  c_valid;
    logic [15:0] c_data;
    logic [1:0]  c_ready;
    logic [7:0]  c_count;
    logic [15:0] c_sig;
    logic [1:0]  c_ovf;

    bsc_stub_sink #(
        .NUM_CH(2), .WIDTH(8), .MODE(0), .READY_PERIOD(4), .CNT_WIDTH(3)
    ) u_a (
        .clk(clk), .reset(rst), .clear(a_clear), .in_valid(a_valid), .in_data(a_data),
        .in_ready(a_ready), .beat_count(a_count), .signature(a_sig), .overflow(a_ovf)
    );

    bsc_stub_sink #(
        .NUM_CH(1), .WIDTH(8), .MODE(1), .READY_PERIOD(4), .CNT_WIDTH(8)
    ) u_b (
        .clk(clk), .reset(rst), .clear(b_clear), .in_valid(b_valid), .in_data(b_data),
        .in_ready(b_ready), .beat_count(b_count), .signature(b_sig), .overflow(b_ovf)
    );

    bsc_stub_sink #(
        .NUM_CH(2), .WIDTH(8), .MODE(2), .READY_PERIOD(4), .CNT_WIDTH(4)
    ) u_c (
        .clk(clk), .reset(rst), .clear(c_clear), .in_valid(c_valid), .in_data(c_data),
        .in_ready(c_ready), .beat_count(c_count), .signature(c_sig), .overflow(c_ovf)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;

    // Model: beats accepted since last clear/reset and the running signature.
    int unsigned a_n[2];
    logic [7:0]  a_s[2];
    int unsigned b_n;
    logic [7:0]  b_s;
    int unsigned b_cyc;

    function automatic logic [7:0] sig_step(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], s[7]} ^ d;
    endfunction

    function automatic int unsigned sat(input int unsigned n, input int unsigned max);
        return (n > max) ? max : n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            a_n[c] = 0;
            a_s[c] = 8'h00;
        end
        b_n   = 0;
        b_s   = 8'h00;
        b_cyc = 0;
    endtask

    task automatic check_outputs();
        logic [5:0]  ea_cnt;
        logic [15:0] ea_sig;
        logic [1:0]  ea_ovf;
        for (int c = 0; c < 2; c++) begin
            ea_cnt[c*3 +: 3] = 3'(sat(a_n[c], 7));
            ea_sig[c*8 +: 8] = a_s[c];
            ea_ovf[c]        = (a_n[c] > 7);
        end
        check("a_count", 32'(a_count), 32'(ea_cnt));
        check("a_sig", 32'(a_sig), 32'(ea_sig));
        check("a_ovf", 32'(a_ovf), 32'(ea_ovf));
        check("b_count", 32'(b_count), 32'(sat(b_n, 255)));
        check("b_sig", 32'(b_sig), 32'(b_s));
        check("b_ovf", 32'(b_ovf), 32'(b_n > 255));
        check("c_count", 32'(c_count), 32'h0);
        check("c_sig", 32'(c_sig), 32'h0);
        check("c_ovf", 32'(c_ovf), 32'h0);
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic tick();
        logic ra, rb;
        #1;
        ra = !a_clear;
        rb = !b_clear && ((b_cyc % 4) == 3);
        check("a_ready", 32'(a_ready), 32'({ra, ra}));
        check("b_ready", 32'(b_ready), 32'(rb));
        check("c_ready", 32'(c_ready), 32'h0);
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (a_clear) begin
                a_n[c] = 0;
                a_s[c] = 8'h00;
            end else if (a_valid[c] && ra) begin
                a_n[c]++;
                a_s[c] = sig_step(a_s[c], a_data[c*8 +: 8]);
            end
        end
        if (b_clear) begin
            b_n   = 0;
            b_s   = 8'h00;
            b_cyc = 0;
        end else begin
            if (b_valid && rb) begin
                b_n++;
                b_s = sig_step(b_s, b_data);
            end
            b_cyc++;
        end
        #1;
        check_outputs();
    endtask

    initial begin
        rst     = 1'b1;
        a_clear = 1'b0;
        b_clear = 1'b0;
        c_clear = 1'b0;
        a_valid = 2'b00;
        a_data  = 16'h0;
        b_valid = 1'b0;
        b_data  = 8'h0;
        c_valid = 2'b11;
        c_data  = 16'hA5C3;
        model_reset();

        #2;
        check_outputs();
        check("rst_a_ready", 32'(a_ready), 32'h0);
        check("rst_b_ready", 32'(b_ready), 32'h0);
        #1 rst = 1'b0;

        // Directed: three beats on A ch0; B valid held from reset release for 16 cycles.
        b_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_valid = (i < 3) ? 2'b01 : 2'b00;
            a_data  = {8'h5A, 8'(i + 1)};
            b_data  = 8'($urandom);
            tick();
        end
        check("t1_count0", 32'(a_count[2:0]), 32'd3);
        check("t1_sig0", 32'(a_sig[7:0]), 32'h03);
        check("t1_count1", 32'(a_count[5:3]), 32'd0);
        check("t1_sig1", 32'(a_sig[15:8]), 32'h00);
        check("t2_count", 32'(b_count), 32'd4);

        for (int i = 0; i < 60; i++) begin
            a_valid = 2'($urandom);
            a_data  = 16'($urandom);
            a_clear = ($urandom_range(7) == 0);
            b_valid = 1'($urandom);
            b_data  = 8'($urandom);
            b_clear = ($urandom_range(9) == 0);
            c_data  = 16'($urandom);
            tick();
        end
        a_clear = 1'b0;
        b_clear = 1'b0;

        // Saturation: nine back-to-back beats on a 3-bit counter.
        a_clear = 1'b1;
        a_valid = 2'b00;
        tick();
        a_clear = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            a_valid = 2'b01;
            a_data  = 16'($urandom);
            tick();
            if (i == 7) check("t3_ovf_at7", 32'(a_ovf[0]), 32'h0);
            if (i == 8) check("t3_ovf_at8", 32'(a_ovf[0]), 32'h1);
        end
        check("t3_count", 32'(a_count[2:0]), 32'd7);

        // Clear with valid held: no beat during clear, beat on the following cycle.
        a_clear = 1'b1;
        a_valid = 2'b00;
        tick();
        a_clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_valid = 2'b01;
            a_data  = 16'($urandom);
            tick();
        end
        check("t4_count5", 32'(a_count[2:0]), 32'd5);
        a_clear = 1'b1;
        tick();
        check("t4_cleared", 32'({a_count[2:0], a_sig[7:0], a_ovf[0]}), 32'h0);
        a_clear = 1'b0;
        tick();
        check("t4_count1", 32'(a_count[2:0]), 32'd1);

        // Reset pulse between edges discards state with no clock edge.
        a_clear = 1'b1;
        a_valid = 2'b00;
        tick();
        a_clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_valid = 2'b11;
            a_data  = 16'($urandom);
            tick();
        end
        check("t5_count6", 32'(a_count[2:0]), 32'd6);
        a_valid = 2'b01;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("t5_a_ready", 32'(a_ready), 32'h0);
        check("t5_b_ready", 32'(b_ready), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            a_valid = 2'($urandom);
            a_data  = 16'($urandom);
            a_clear = ($urandom_range(7) == 0);
            b_valid = 1'($urandom);
            b_data  = 8'($urandom);
            b_clear = ($urandom_range(9) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
